kat_violation_logger: RTL and testbench
=======================================

# kat_violation_logger

Response-side partner to the KAT instruction monitor. It consumes the monitor's registered `r` (restricted-register write) and `j` (protected-region jump) flags, re-aligns them with the instruction that caused them, and buffers violation records in a FIFO. Software drains the FIFO through a valid/ready port. An escalation state machine raises `irq` and, after a programmable number of jump violations, `halt` toward the core.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries. Power of two, at least 2.
- `HALT_THRESH`, 4: number of jump-violation events that forces HALT. Range 1..255.

Ports:
- `clk`  in  1  single clock. All logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `pc`/`inst` presented to the monitor are valid this cycle.
- `pc`  in  32  the same `pc` driven to the monitor.
- `inst`  in  32  the same `inst` driven to the monitor.
- `r`  in  1  monitor output: restricted-register write.
- `j`  in  1  monitor output: protected jump.
- `rd_valid`  out  1  a record is available at the head of the FIFO.
- `rd_ready`  in  1  the consumer accepts the head record.
- `rd_kind`  out  2  violation kind of the head record.
- `rd_pc`  out  32  pc of the head record.
- `rd_inst`  out  32  inst of the head record.
- `irq`  out  1  raised when records are pending or the FIFO has overflowed.
- `halt`  out  1  core stall request.
- `halt_clr`  in  1  single-cycle pulse that leaves HALT.
- `overflow`  out  1  sticky: at least one record has been dropped.
- `drop_cnt`  out  8  saturating count of dropped records.

## Operation
- Alignment: the monitor's flags lag its inputs by one edge.
  - Stage s1 captures {`in_valid`, `pc`, `inst`} at edge k.
  - Stage s2 takes s1 at edge k+1.
  - During the cycle after edge k+1, s2 is aligned with `r`/`j`.
- Event: `s2.valid && (r || j)`.
  - kind = {j, r}: 01 = r only, 10 = j only, 11 = both.
  - The monitor holds its flags on unmatched opcodes. Only qualified s2 slots count as events, so one held flag does not create duplicate records unless `in_valid` repeats.
- Push: the event record {kind, pc, inst} is written at the edge after alignment.
- Pop: on `rd_valid && rd_ready`.
- Full with no pop: the event is dropped.
  - `overflow` is set.
  - `drop_cnt` increments and saturates at 255.
- Full with a pop in the same cycle: the push is accepted and the occupancy is unchanged.
- Empty: `rd_valid` = 0. The `rd_*` data outputs hold their last value and are don't-care.
- Jump counter `jcnt` (8 bits) increments on every event with j = 1, whether the record is stored or dropped. It saturates at `HALT_THRESH`.
- State machine, with HALT taking priority:
  - NORMAL: FIFO empty and no overflow.
  - ALERT: FIFO non-empty or `overflow` = 1.
  - HALT: entered when `jcnt` reaches `HALT_THRESH`.
  - NORMAL ↔ ALERT: follows the current condition each cycle.
  - ALERT or NORMAL → HALT: on the threshold.
  - HALT → NORMAL or ALERT: on `halt_clr` (re-evaluated); `jcnt` is cleared.
- `irq` = state != NORMAL. `halt` = state == HALT.
- Logging continues in every state.
- `halt_clr` and a j event in the same cycle:
  - the clear wins, `jcnt` becomes 0;
  - the event is still logged.
- `halt_clr` outside HALT is ignored.
- `overflow` and `drop_cnt` are cleared only by reset.

## Timing
- Reset (async assert, sync deassert is the integrator's job) drives every output low or zero:
  - `rd_valid`, `rd_kind`, `rd_pc`, `rd_inst`, `irq`, `halt`, `overflow`, `drop_cnt` = 0;
  - FIFO pointers, `jcnt`, s1 and s2 are cleared; state = NORMAL.
- Reset during a pending handshake discards all records.
- Latency, with the instruction presented at edge k and the FIFO empty:
  - `rd_valid` rises after edge k+2;
  - `irq` rises after edge k+3.
- HALT latency: `halt` rises one edge after the push of the threshold-reaching j event.
- Throughput: one push and one pop per cycle.
- `rd_*` outputs come directly from storage and the read pointer, with no extra register stage.

## Configuration
- `KAT_LOG_INST_EN` defined: records store `inst`, and `rd_inst` carries it.
- Not defined:
  - `inst` storage and the s1/s2 inst fields are omitted;
  - `rd_inst` is tied to 0;
  - all other behaviour is identical.

## Structure
- Package `kat_pkg` holds:
  - the kind encodings `KIND_R` = 2'b01, `KIND_J` = 2'b10, `KIND_RJ` = 2'b11;
  - the state encoding (NORMAL, ALERT, HALT);
  - the record width constant, which depends on the macro.
- Sub-module `kat_sync_fifo`: parameterized width and depth, push/pop, full/empty, simultaneous push and pop when full.
- The alignment stages, counters and state machine stay in the top level.

## Test plan
- Single r event: `in_valid` = 1, pc = 0x0040_0010, inst = 0x0000_0020 with r = 1 at the aligned cycle → `rd_valid` rises after edge k+2, `rd_kind` = 01, `rd_pc` = 0x0040_0010; `irq` = 1 until popped, then 0.
- Held flag: r stays 1 while `in_valid` = 0 for 5 cycles → exactly one record.
- Overflow with `DEPTH` = 8 and `rd_ready` = 0: 10 events → 8 stored, `drop_cnt` = 2, `overflow` = 1; draining all records leaves `irq` = 1.
- Full with simultaneous push and pop → occupancy stays 8, `drop_cnt` unchanged, record order preserved.
- `HALT_THRESH` = 4: four j events → `halt` = 1; `halt_clr` pulsed in the same cycle as a fifth j event → `halt` = 0, `jcnt` = 0, fifth record present.
- Assert `rst_n` = 0 mid-stream with 3 records pending → all outputs 0 immediately; after release `rd_valid` stays 0 until a new event.

Source files
------------

// File: rtl/kat_pkg.sv
// rtl/kat_pkg.sv - shared encodings for the KAT violation logger; record width follows KAT_LOG_INST_EN
package kat_pkg;

    localparam logic [1:0] KIND_R  = 2'b01;
    localparam logic [1:0] KIND_J  = 2'b10;
    localparam logic [1:0] KIND_RJ = 2'b11;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        ALERT  = 2'd1,
        HALT   = 2'd2
    } kat_state_e;

`ifdef KAT_LOG_INST_EN
    localparam int REC_W = 2 + 32 + 32;
`else
    localparam int REC_W = 2 + 32;
`endif

endpackage

// File: rtl/kat_sync_fifo.sv
// rtl/kat_sync_fifo.sv - synchronous FIFO; a push is accepted when full if a pop happens in the same cycle
module kat_sync_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is reset so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/kat_violation_logger.sv
// rtl/kat_violation_logger.sv - aligns KAT monitor flags, logs violation records, escalates irq/halt; KAT_LOG_INST_EN keeps inst
module kat_violation_logger
    import kat_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int HALT_THRESH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    input  logic        r,
    input  logic        j,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [1:0]  rd_kind,
    output logic [31:0] rd_pc,
    output logic [31:0] rd_inst,
    output logic        irq,
    output logic        halt,
    input  logic        halt_clr,
    output logic        overflow,
    output logic [7:0]  drop_cnt
);
    localparam logic [7:0] THRESH = 8'(HALT_THRESH);

    logic        s1_valid_q, s2_valid_q;
    logic [31:0] s1_pc_q, s2_pc_q;
`ifdef KAT_LOG_INST_EN
    logic [31:0] s1_inst_q, s2_inst_q;
`else
    logic        unused_inst;
    assign unused_inst = ^inst;
`endif

    logic             ev, pop, drop;
    logic             fifo_full, fifo_empty;
    logic [1:0]       ev_kind;
    logic [REC_W-1:0] ev_rec, head_rec;

    logic [7:0] jcnt_q, jcnt_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic       overflow_q, overflow_d;
    logic       alert_cond;
    kat_state_e state_q, state_d;

    // Two stages so s2 lines up with the monitor's registered flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_pc_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_pc_q    <= '0;
        end else begin
            s1_valid_q <= in_valid;
            s1_pc_q    <= pc;
            s2_valid_q <= s1_valid_q;
            s2_pc_q    <= s1_pc_q;
        end
    end

`ifdef KAT_LOG_INST_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_inst_q <= '0;
            s2_inst_q <= '0;
        end else begin
            s1_inst_q <= inst;
            s2_inst_q <= s1_inst_q;
        end
    end
    assign ev_rec = {ev_kind, s2_pc_q, s2_inst_q};
`else
    assign ev_rec = {ev_kind, s2_pc_q};
`endif

    // A held monitor flag only counts against a qualified s2 slot.
    assign ev      = s2_valid_q && (r || j);
    assign ev_kind = {j, r};
    assign pop     = !fifo_empty && rd_ready;
    assign drop    = ev && fifo_full && !pop;

    kat_sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (ev),
        .push_data_i (ev_rec),
        .pop_i       (pop),
        .head_o      (head_rec),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign rd_valid = !fifo_empty;
    assign rd_kind  = head_rec[REC_W-1 -: 2];
    assign rd_pc    = head_rec[REC_W-3 -: 32];
`ifdef KAT_LOG_INST_EN
    assign rd_inst  = head_rec[31:0];
`else
    assign rd_inst  = '0;
`endif

    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    // A clear from HALT beats a same-cycle jump event; the event itself is still logged.
    always_comb begin
        jcnt_d = jcnt_q;
        if ((state_q == HALT) && halt_clr) begin
            jcnt_d = '0;
        end else if (ev && j && (jcnt_q < THRESH)) begin
            jcnt_d = jcnt_q + 8'd1;
        end
    end

    always_comb begin
        alert_cond = !fifo_empty || overflow_q;
        state_d    = state_q;
        case (state_q)
            HALT: begin
                if (halt_clr) begin
                    state_d = alert_cond ? ALERT : NORMAL;
                end
            end
            default: begin
                if (jcnt_q >= THRESH) begin
                    state_d = HALT;
                end else begin
                    state_d = alert_cond ? ALERT : NORMAL;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jcnt_q     <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
            state_q    <= NORMAL;
        end else begin
            jcnt_q     <= jcnt_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
        end
    end

    assign irq      = (state_q != NORMAL);
    assign halt     = (state_q == HALT);
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_kat_violation_logger.sv
// tb/tb_kat_violation_logger.sv - directed self-checking bench for kat_violation_logger
module tb_kat_violation_logger;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] inst = '0;
    logic        r = 1'b0;
    logic        j = 1'b0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [1:0]  rd_kind;
    logic [31:0] rd_pc;
    logic [31:0] rd_inst;
    logic        irq;
    logic        halt;
    logic        halt_clr = 1'b0;
    logic        overflow;
    logic [7:0]  drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef KAT_LOG_INST_EN
    localparam logic [31:0] INST_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] INST_MASK = 32'h0;
`endif

    always #5 clk = ~clk;

    kat_violation_logger #(
        .DEPTH       (8),
        .HALT_THRESH (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .pc       (pc),
        .inst     (inst),
        .r        (r),
        .j        (j),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_kind  (rd_kind),
        .rd_pc    (rd_pc),
        .rd_inst  (rd_inst),
        .irq      (irq),
        .halt     (halt),
        .halt_clr (halt_clr),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    task automatic step(input logic iv, input logic [31:0] p, input logic [31:0] ins,
                        input logic rr, input logic jj);
        @(negedge clk);
        in_valid = iv;
        pc       = p;
        inst     = ins;
        r        = rr;
        j        = jj;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if ({rd_valid, irq, halt, overflow} !== 4'b0000) begin n_bad++;
            $display("FAIL reset_flags: got %b expected 0000", {rd_valid, irq, halt, overflow}); end
        n_cmp++; if (rd_kind !== 2'b00) begin n_bad++;
            $display("FAIL reset_kind: got %b expected 00", rd_kind); end
        n_cmp++; if (rd_pc !== 32'h0) begin n_bad++;
            $display("FAIL reset_pc: got %h expected 0", rd_pc); end
        n_cmp++; if (rd_inst !== 32'h0) begin n_bad++;
            $display("FAIL reset_inst: got %h expected 0", rd_inst); end
        n_cmp++; if (drop_cnt !== 8'h0) begin n_bad++;
            $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_r();
        step(1'b1, 32'h0040_0010, 32'h0000_0020, 1'b0, 1'b0);
        idle();
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++;
            $display("FAIL single_valid_k: got %b expected 0", rd_valid); end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++;
            $display("FAIL single_valid_k1: got %b expected 0", rd_valid); end
        idle();
        n_cmp++; if ({rd_valid, rd_kind, rd_pc} !== {1'b1, 2'b01, 32'h0040_0010}) begin n_bad++;
            $display("FAIL single_record: got v=%b k=%b pc=%h expected v=1 k=01 pc=00400010",
                     rd_valid, rd_kind, rd_pc); end
        n_cmp++; if (rd_inst !== (32'h0000_0020 & INST_MASK)) begin n_bad++;
            $display("FAIL single_inst: got %h expected %h", rd_inst, 32'h0000_0020 & INST_MASK); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++;
            $display("FAIL single_irq_k2: got %b expected 0", irq); end
        idle();
        n_cmp++; if (irq !== 1'b1) begin n_bad++;
            $display("FAIL single_irq_k3: got %b expected 1", irq); end
        rd_ready = 1'b1;
        idle();
        rd_ready = 1'b0;
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++;
            $display("FAIL single_pop: got %b expected 0", rd_valid); end
        idle();
        n_cmp++; if (irq !== 1'b0) begin n_bad++;
            $display("FAIL single_irq_clear: got %b expected 0", irq); end
    endtask

    task automatic test_held_flag();
        step(1'b1, 32'h0040_0100, 32'h0000_0011, 1'b0, 1'b0);
        idle();
        for (int c = 0; c < 6; c++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle();
        n_cmp++; if ({rd_valid, rd_pc} !== {1'b1, 32'h0040_0100}) begin n_bad++;
            $display("FAIL held_record: got v=%b pc=%h expected v=1 pc=00400100", rd_valid, rd_pc); end
        rd_ready = 1'b1;
        idle();
        rd_ready = 1'b0;
        repeat (3) idle();
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++;
            $display("FAIL held_single: got %b expected 0", rd_valid); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++;
            $display("FAIL held_irq: got %b expected 0", irq); end
    endtask

    task automatic test_overflow();
        for (int c = 0; c < 12; c++)
            step(c < 10, 32'h1000 + 32'(4 * c), 32'(c), c >= 2, 1'b0);
        idle();
        n_cmp++; if (drop_cnt !== 8'd2) begin n_bad++;
            $display("FAIL ovf_drop_cnt: got %0d expected 2", drop_cnt); end
        n_cmp++; if ({overflow, irq} !== 2'b11) begin n_bad++;
            $display("FAIL ovf_flags: got %b expected 11", {overflow, irq}); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if ({rd_valid, rd_pc} !== {1'b1, 32'h1000 + 32'(4 * i)}) begin n_bad++;
                $display("FAIL ovf_drain_%0d: got v=%b pc=%h expected v=1 pc=%h",
                         i, rd_valid, rd_pc, 32'h1000 + 32'(4 * i)); end
            rd_ready = 1'b1;
            idle();
        end
        rd_ready = 1'b0;
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++;
            $display("FAIL ovf_stored_count: got %b expected 0", rd_valid); end
        repeat (2) idle();
        n_cmp++; if (irq !== 1'b1) begin n_bad++;
            $display("FAIL ovf_irq_sticky: got %b expected 1", irq); end
    endtask

    task automatic test_full_pop();
        for (int c = 0; c < 11; c++) begin
            step(c < 9, 32'h2000 + 32'(4 * c), 32'h100 + 32'(c), c >= 2, 1'b0);
            rd_ready = (c == 10);
        end
        idle();
        rd_ready = 1'b0;
        n_cmp++; if (drop_cnt !== 8'd2) begin n_bad++;
            $display("FAIL full_pop_drop_cnt: got %0d expected 2", drop_cnt); end
        for (int i = 1; i < 9; i++) begin
            n_cmp++; if ({rd_valid, rd_kind, rd_pc} !== {1'b1, 2'b01, 32'h2000 + 32'(4 * i)}) begin n_bad++;
                $display("FAIL full_pop_order_%0d: got v=%b k=%b pc=%h expected v=1 k=01 pc=%h",
                         i, rd_valid, rd_kind, rd_pc, 32'h2000 + 32'(4 * i)); end
            rd_ready = 1'b1;
            idle();
        end
        rd_ready = 1'b0;
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++;
            $display("FAIL full_pop_occupancy: got %b expected 0", rd_valid); end
    endtask

    task automatic test_halt();
        for (int c = 0; c < 8; c++) begin
            step(c < 4, 32'h3000 + 32'(4 * c), 32'h200 + 32'(c), 1'b0, (c >= 2) && (c < 6));
            if (c == 6) begin
                n_cmp++; if (halt !== 1'b0) begin n_bad++;
                    $display("FAIL halt_early: got %b expected 0", halt); end
            end
            if (c == 7) begin
                n_cmp++; if (halt !== 1'b1) begin n_bad++;
                    $display("FAIL halt_rise: got %b expected 1", halt); end
            end
        end
        step(1'b1, 32'h3010, 32'h204, 1'b0, 1'b0);
        idle();
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        halt_clr = 1'b1;
        idle();
        halt_clr = 1'b0;
        n_cmp++; if ({halt, irq} !== 2'b01) begin n_bad++;
            $display("FAIL halt_clr: got halt=%b irq=%b expected halt=0 irq=1", halt, irq); end
        n_cmp++; if (dut.jcnt_q !== 8'd0) begin n_bad++;
            $display("FAIL jcnt_clr: got %0d expected 0", dut.jcnt_q); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if ({rd_valid, rd_kind, rd_pc} !==
                         {1'b1, (i == 4) ? 2'b11 : 2'b10, 32'h3000 + 32'(4 * i)}) begin n_bad++;
                $display("FAIL halt_record_%0d: got v=%b k=%b pc=%h", i, rd_valid, rd_kind, rd_pc); end
            rd_ready = 1'b1;
            idle();
        end
        rd_ready = 1'b0;
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++;
            $display("FAIL halt_record_count: got %b expected 0", rd_valid); end
    endtask

    task automatic test_clr_ignored();
        for (int c = 0; c < 5; c++)
            step(c < 3, 32'h4000 + 32'(4 * c), 32'h0, 1'b0, c >= 2);
        repeat (2) idle();
        n_cmp++; if (halt !== 1'b0) begin n_bad++;
            $display("FAIL three_j_no_halt: got %b expected 0", halt); end
        halt_clr = 1'b1;
        idle();
        halt_clr = 1'b0;
        step(1'b1, 32'h400c, 32'h0, 1'b0, 1'b0);
        idle();
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        repeat (2) idle();
        n_cmp++; if (halt !== 1'b1) begin n_bad++;
            $display("FAIL clr_ignored: got %b expected 1", halt); end
        halt_clr = 1'b1;
        idle();
        halt_clr = 1'b0;
        n_cmp++; if ({halt, irq} !== 2'b01) begin n_bad++;
            $display("FAIL halt_exit_alert: got halt=%b irq=%b expected halt=0 irq=1", halt, irq); end
    endtask

    task automatic test_reset_midstream();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++)
            step(c < 3, 32'h5000 + 32'(4 * c), 32'h300 + 32'(c), c >= 2, 1'b0);
        idle();
        rd_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({rd_valid, irq, halt, overflow, rd_kind} !== 6'b0) begin n_bad++;
            $display("FAIL midreset_flags: got %b expected 000000", {rd_valid, irq, halt, overflow, rd_kind}); end
        n_cmp++; if ({rd_pc, rd_inst, drop_cnt} !== 72'h0) begin n_bad++;
            $display("FAIL midreset_data: got pc=%h inst=%h drop=%0d expected 0", rd_pc, rd_inst, drop_cnt); end
        rd_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) idle();
        n_cmp++; if ({rd_valid, irq} !== 2'b00) begin n_bad++;
            $display("FAIL midreset_empty: got %b expected 00", {rd_valid, irq}); end
        step(1'b1, 32'h5100, 32'h0, 1'b0, 1'b0);
        idle();
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle();
        n_cmp++; if ({rd_valid, rd_pc} !== {1'b1, 32'h5100}) begin n_bad++;
            $display("FAIL midreset_new_event: got v=%b pc=%h expected v=1 pc=00005100", rd_valid, rd_pc); end
    endtask

    initial begin
        test_reset();
        test_single_r();
        test_held_flag();
        test_overflow();
        test_full_pop();
        test_halt();
        test_clr_ignored();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
